// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with optional skid entry, stall/flush and stall counter
module pipe_stage_reg #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 4,
    parameter int SKID_EN    = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  stall_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [CTRL_WIDTH-1:0] out_ctrl_o,
    output logic [1:0]            occupancy_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;
    state_t state, state_nxt;
    logic main_v, skid_v, in_xfer, out_xfer;
    logic load_main, load_skid, pop_skid;
    logic [DATA_WIDTH-1:0] main_data, skid_data;
    logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
    assign main_v      = state != EMPTY;
    assign skid_v      = state == SKID;
    assign out_valid_o = main_v & ~stall_i;
    assign in_ready_o  = (SKID_EN != 0 ? ~skid_v : (~main_v | out_ready_i)) & ~stall_i & ~rst;
    assign in_xfer     = in_valid_i & in_ready_o;
    assign out_xfer    = out_valid_o & out_ready_i;
    assign out_data_o  = main_data;
    assign out_ctrl_o  = main_v ? main_ctrl : '0;
    assign occupancy_o = {1'b0, main_v} + {1'b0, skid_v};
    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: if (in_xfer) begin
                state_nxt = FULL;
                load_main = 1'b1;
            end
            FULL: if (in_xfer && out_xfer) load_main = 1'b1;
                else if (out_xfer) state_nxt = EMPTY;
                else if (in_xfer && SKID_EN != 0) begin
                    state_nxt = SKID;
                    load_skid = 1'b1;
                end
            SKID: if (out_xfer) begin
                state_nxt = FULL;
                pop_skid  = 1'b1;
            end
            default: state_nxt = EMPTY;
        endcase
        // flush kills held items and anything handshaked this cycle, data regs keep their contents
        if (flush_i) begin
            state_nxt = EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            pop_skid  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nxt;
            if (load_main) begin
                main_data <= in_data_i;
                main_ctrl <= in_ctrl_i;
            end else if (pop_skid) begin
                main_data <= skid_data;
                main_ctrl <= skid_ctrl;
            end
            if (load_skid) begin
                skid_data <= in_data_i;
                skid_ctrl <= in_ctrl_i;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_o <= '0;
        else if (main_v && (stall_i || !out_ready_i) && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of skid, non-skid and narrow-counter configurations
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst = 1'b1, flush = 1'b0, stall = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [63:0] in_data = '0;
    logic [3:0] in_ctrl = '0;
    logic rdy_a, vld_a, rdy_s, vld_s, rdy_n, vld_n;
    logic [63:0] data_a, data_s, data_n;
    logic [3:0] ctrl_a, ctrl_s, ctrl_n, cnt_s;
    logic [1:0] occ_a, occ_s, occ_n;
    logic [15:0] cnt_a, cnt_n;
    int passed = 0, total = 0;
    always #5 clk = ~clk;
    pipe_stage_reg dut (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(vld_a), .out_ready_i(out_ready),
        .out_data_o(data_a), .out_ctrl_o(ctrl_a), .occupancy_o(occ_a), .stall_cnt_o(cnt_a)
    );
    pipe_stage_reg #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(vld_s), .out_ready_i(out_ready),
        .out_data_o(data_s), .out_ctrl_o(ctrl_s), .occupancy_o(occ_s), .stall_cnt_o(cnt_s)
    );
    pipe_stage_reg #(.SKID_EN(0)) dut_ns (
        .clk(clk), .rst(rst), .flush_i(flush), .stall_i(stall), .in_valid_i(in_valid), .in_ready_o(rdy_n),
        .in_data_i(in_data), .in_ctrl_i(in_ctrl), .out_valid_o(vld_n), .out_ready_i(out_ready),
        .out_data_o(data_n), .out_ctrl_o(ctrl_n), .occupancy_o(occ_n), .stall_cnt_o(cnt_n)
    );
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        tick();
        rst = 1'b0;
        #1;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (rdy_a !== 1'b0) $display("FAIL reset_ready got %b exp 0", rdy_a); else passed++;
        total++; if (vld_a !== 1'b0) $display("FAIL reset_valid got %b exp 0", vld_a); else passed++;
        total++; if (data_a !== 64'h0) $display("FAIL reset_data got %h exp 0", data_a); else passed++;
        total++; if (ctrl_a !== 4'h0) $display("FAIL reset_ctrl got %h exp 0", ctrl_a); else passed++;
        total++; if (occ_a !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occ_a); else passed++;
        total++; if (cnt_a !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", cnt_a); else passed++;
        rst = 1'b0;
        #1;
        total++; if (rdy_a !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", rdy_a); else passed++;
    endtask
    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 64'(i); in_ctrl = 4'(i);
            tick();
            total++; if (vld_a !== 1'b1 || data_a !== 64'(i)) $display("FAIL stream_item%0d got v=%b d=%h exp v=1 d=%h", i, vld_a, data_a, 64'(i)); else passed++;
            total++; if (occ_a !== 2'd1) $display("FAIL stream_occ%0d got %0d exp 1", i, occ_a); else passed++;
        end
        in_valid = 1'b0;
        tick();
        total++; if (occ_a !== 2'd0) $display("FAIL stream_drain got %0d exp 0", occ_a); else passed++;
    endtask
    task automatic test_back_pressure();
        do_reset();
        in_valid = 1'b1; in_data = 64'hA; in_ctrl = 4'h1;
        tick();
        in_data = 64'hB; in_ctrl = 4'h2;
        #1;
        total++; if (rdy_a !== 1'b1) $display("FAIL bp_ready_full got %b exp 1", rdy_a); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (occ_a !== 2'd2) $display("FAIL bp_occ got %0d exp 2", occ_a); else passed++;
        total++; if (rdy_a !== 1'b0) $display("FAIL bp_ready_skid got %b exp 0", rdy_a); else passed++;
        tick();
        tick();
        total++; if (cnt_a !== 16'd3) $display("FAIL bp_cnt got %0d exp 3", cnt_a); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (vld_a !== 1'b1 || data_a !== 64'hA) $display("FAIL bp_first got v=%b d=%h exp v=1 d=a", vld_a, data_a); else passed++;
        tick();
        total++; if (vld_a !== 1'b1 || data_a !== 64'hB || ctrl_a !== 4'h2) $display("FAIL bp_second got v=%b d=%h c=%h exp v=1 d=b c=2", vld_a, data_a, ctrl_a); else passed++;
        total++; if (rdy_a !== 1'b1 || occ_a !== 2'd1) $display("FAIL bp_after_drain got rdy=%b occ=%0d exp rdy=1 occ=1", rdy_a, occ_a); else passed++;
        tick();
        total++; if (occ_a !== 2'd0 || cnt_a !== 16'd3) $display("FAIL bp_end got occ=%0d cnt=%0d exp occ=0 cnt=3", occ_a, cnt_a); else passed++;
    endtask
    task automatic test_flush();
        do_reset();
        in_valid = 1'b1; in_data = 64'h11; in_ctrl = 4'hF;
        tick();
        in_data = 64'h22;
        tick();
        total++; if (occ_a !== 2'd2 || ctrl_a !== 4'hF) $display("FAIL flush_pre got occ=%0d c=%h exp occ=2 c=f", occ_a, ctrl_a); else passed++;
        flush = 1'b1; in_data = 64'h33;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (vld_a !== 1'b0 || ctrl_a !== 4'h0 || occ_a !== 2'd0) $display("FAIL flush_skid got v=%b c=%h occ=%0d exp 0 0 0", vld_a, ctrl_a, occ_a); else passed++;
        total++; if (data_a !== 64'h11) $display("FAIL flush_data_hold got %h exp 11", data_a); else passed++;
        in_valid = 1'b1; in_data = 64'h44; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        total++; if (vld_a !== 1'b0 || occ_a !== 2'd0 || data_a !== 64'h11) $display("FAIL flush_input got v=%b occ=%0d d=%h exp v=0 occ=0 d=11", vld_a, occ_a, data_a); else passed++;
        tick();
        total++; if (vld_a !== 1'b0) $display("FAIL flush_never_out got %b exp 0", vld_a); else passed++;
    endtask
    task automatic test_stall();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h55; in_ctrl = 4'h3;
        tick();
        stall = 1'b1; in_data = 64'h66;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (vld_a !== 1'b0 || rdy_a !== 1'b0) $display("FAIL stall_cycle%0d got v=%b rdy=%b exp 0 0", i, vld_a, rdy_a); else passed++;
            total++; if (ctrl_a !== 4'h3) $display("FAIL stall_ctrl%0d got %h exp 3", i, ctrl_a); else passed++;
            tick();
        end
        stall = 1'b0; in_valid = 1'b0;
        #1;
        total++; if (vld_a !== 1'b1 || data_a !== 64'h55) $display("FAIL stall_release got v=%b d=%h exp v=1 d=55", vld_a, data_a); else passed++;
        total++; if (cnt_a !== 16'd3) $display("FAIL stall_cnt got %0d exp 3", cnt_a); else passed++;
        tick();
        total++; if (occ_a !== 2'd0) $display("FAIL stall_drain got %0d exp 0", occ_a); else passed++;
    endtask
    task automatic test_saturation();
        do_reset();
        in_valid = 1'b1; in_data = 64'h77; in_ctrl = 4'h5;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        total++; if (cnt_s !== 4'd15) $display("FAIL sat_cnt got %0d exp 15", cnt_s); else passed++;
        total++; if (cnt_a !== 16'd20) $display("FAIL sat_wide_cnt got %0d exp 20", cnt_a); else passed++;
        rst = 1'b1;
        tick();
        total++; if (cnt_s !== 4'd0 || vld_s !== 1'b0 || occ_s !== 2'd0) $display("FAIL sat_reset got cnt=%0d v=%b occ=%0d exp 0 0 0", cnt_s, vld_s, occ_s); else passed++;
        total++; if (data_s !== 64'h0 || ctrl_s !== 4'h0 || rdy_s !== 1'b0) $display("FAIL sat_reset_out got d=%h c=%h rdy=%b exp 0 0 0", data_s, ctrl_s, rdy_s); else passed++;
        rst = 1'b0;
    endtask
    task automatic test_no_skid();
        do_reset();
        in_valid = 1'b1; in_data = 64'hA; in_ctrl = 4'h1;
        tick();
        in_data = 64'hB; in_ctrl = 4'h2;
        #1;
        total++; if (rdy_n !== 1'b0) $display("FAIL ns_ready_blocked got %b exp 0", rdy_n); else passed++;
        tick();
        total++; if (occ_n !== 2'd1 || data_n !== 64'hA) $display("FAIL ns_hold got occ=%0d d=%h exp occ=1 d=a", occ_n, data_n); else passed++;
        out_ready = 1'b1;
        #1;
        total++; if (rdy_n !== 1'b1 || data_n !== 64'hA) $display("FAIL ns_ready_follow got rdy=%b d=%h exp rdy=1 d=a", rdy_n, data_n); else passed++;
        tick();
        in_valid = 1'b0;
        #1;
        total++; if (vld_n !== 1'b1 || data_n !== 64'hB || occ_n !== 2'd1) $display("FAIL ns_second got v=%b d=%h occ=%0d exp v=1 d=b occ=1", vld_n, data_n, occ_n); else passed++;
        tick();
        total++; if (occ_n !== 2'd0) $display("FAIL ns_drain got %0d exp 0", occ_n); else passed++;
    endtask
    initial begin
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_stall();
        test_saturation();
        test_no_skid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
